// File: rtl/segment_swapchain.sv
// segment_swapchain: segment sequencer for the modulation / STM memory read path.
// Owns the read index for NUM_SEGMENTS memory segments. Each segment is played
// REP+1 times (all-ones REP = forever). Segment changes are either immediate or
// deferred until the active segment next wraps.
//
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   UPDATE         1-cycle host commit; REQ_SEGMENT / REQ_MODE sampled with it
//   REQ_SEGMENT    requested segment
//   REQ_MODE       0 = immediate switch, 1 = switch at next wrap
//   CYCLE          per-segment last index, packed, segment 0 in LSBs
//   REP            per-segment repeat count, packed, segment 0 in LSBs
//   STEP           1-cycle advance strobe
//   SEGMENT, IDX   active segment and read index
//   STOP           finite repeats exhausted, IDX held at last index
//   PENDING        deferred swap waiting for a wrap
//   REQ_ERR        1-cycle pulse: out-of-range request dropped
module segment_swapchain #(
    parameter int unsigned NUM_SEGMENTS = 2,
    parameter int unsigned IDX_WIDTH    = 15,
    parameter int unsigned REP_WIDTH    = 16,
    localparam int unsigned SEG_W = (NUM_SEGMENTS > 2) ? $clog2(NUM_SEGMENTS) : 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              UPDATE,
    input  logic [SEG_W-1:0]                  REQ_SEGMENT,
    input  logic                              REQ_MODE,
    input  logic [NUM_SEGMENTS*IDX_WIDTH-1:0] CYCLE,
    input  logic [NUM_SEGMENTS*REP_WIDTH-1:0] REP,
    input  logic                              STEP,
    output logic [SEG_W-1:0]                  SEGMENT,
    output logic [IDX_WIDTH-1:0]              IDX,
    output logic                              STOP,
    output logic                              PENDING,
    output logic                              REQ_ERR
);

    // Table padded to a power of two so any SEG_W value indexes in range.
    localparam int unsigned TBL_SIZE = 1 << SEG_W;

    typedef enum logic {StRun, StStopped} state_e;

    logic [IDX_WIDTH-1:0] cyc_tbl [TBL_SIZE];
    logic [REP_WIDTH-1:0] rep_tbl [TBL_SIZE];

    for (genvar g = 0; g < TBL_SIZE; g++) begin : g_tbl
        if (g < NUM_SEGMENTS) begin : g_real
            assign cyc_tbl[g] = CYCLE[g*IDX_WIDTH +: IDX_WIDTH];
            assign rep_tbl[g] = REP[g*REP_WIDTH +: REP_WIDTH];
        end else begin : g_pad
            assign cyc_tbl[g] = '0;
            assign rep_tbl[g] = '0;
        end
    end

    state_e               state_q;
    logic [SEG_W-1:0]     seg_q;
    logic [SEG_W-1:0]     pend_seg_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic [IDX_WIDTH-1:0] cyc_q;
    logic [REP_WIDTH-1:0] rep_q;
    logic [REP_WIDTH-1:0] loop_q;
    logic                 stop_q;
    logic                 pending_q;
    logic                 req_err_q;

    logic             req_valid;
    logic             imm_req;
    logic             sync_req;
    logic             wrap_step;
    logic             do_load;
    logic [SEG_W-1:0] load_seg;

    always_comb begin
        req_valid = 32'(REQ_SEGMENT) < NUM_SEGMENTS;
        imm_req   = UPDATE && req_valid && !REQ_MODE;
        sync_req  = UPDATE && req_valid && REQ_MODE;
        // In StStopped IDX already sits at cyc, so this also covers the stopped case.
        wrap_step = STEP && (idx_q == cyc_q);
        // Deferred swap uses the pending state from before this cycle's UPDATE.
        do_load   = imm_req || (wrap_step && pending_q);
        load_seg  = imm_req ? REQ_SEGMENT : pend_seg_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StRun;
            seg_q      <= '0;
            pend_seg_q <= '0;
            idx_q      <= '0;
            cyc_q      <= '0;
            rep_q      <= '1;
            loop_q     <= '0;
            stop_q     <= 1'b0;
            pending_q  <= 1'b0;
            req_err_q  <= 1'b0;
        end else begin
            req_err_q <= UPDATE && !req_valid;

            if (do_load) begin
                // Entering a segment: restart it and latch its length/repeat fields.
                seg_q     <= load_seg;
                idx_q     <= '0;
                loop_q    <= '0;
                cyc_q     <= cyc_tbl[load_seg];
                rep_q     <= rep_tbl[load_seg];
                stop_q    <= 1'b0;
                pending_q <= 1'b0;
                state_q   <= StRun;
            end else if (STEP && state_q == StRun) begin
                if (!wrap_step) begin
                    idx_q <= idx_q + IDX_WIDTH'(1);
                end else if (rep_q == '1) begin
                    idx_q <= '0;
                end else if (loop_q == rep_q) begin
                    state_q <= StStopped;
                    stop_q  <= 1'b1;
                end else begin
                    idx_q  <= '0;
                    loop_q <= loop_q + REP_WIDTH'(1);
                end
            end

            // Placed last so a request arriving on a swapping wrap stays pending.
            if (sync_req) begin
                pend_seg_q <= REQ_SEGMENT;
                pending_q  <= 1'b1;
            end
        end
    end

    assign SEGMENT = seg_q;
    assign IDX     = idx_q;
    assign STOP    = stop_q;
    assign PENDING = pending_q;
    assign REQ_ERR = req_err_q;

endmodule

// File: tb/tb_segment_swapchain.sv
module tb_segment_swapchain;

    localparam int unsigned NS = 3;
    localparam int unsigned IW = 15;
    localparam int unsigned RW = 16;

    logic          CLK;
    logic          RST;
    logic          UPDATE;
    logic [1:0]    REQ_SEGMENT;
    logic          REQ_MODE;
    logic          STEP;
    logic [1:0]    SEGMENT;
    logic [IW-1:0] IDX;
    logic          STOP;
    logic          PENDING;
    logic          REQ_ERR;

    logic [IW-1:0] cyc_s [NS];
    logic [RW-1:0] rep_s [NS];
    logic [NS*IW-1:0] cycle_bus;
    logic [NS*RW-1:0] rep_bus;

    assign cycle_bus = {cyc_s[2], cyc_s[1], cyc_s[0]};
    assign rep_bus   = {rep_s[2], rep_s[1], rep_s[0]};

    int checks = 0;
    int errors = 0;

    segment_swapchain #(
        .NUM_SEGMENTS(NS),
        .IDX_WIDTH   (IW),
        .REP_WIDTH   (RW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .UPDATE     (UPDATE),
        .REQ_SEGMENT(REQ_SEGMENT),
        .REQ_MODE   (REQ_MODE),
        .CYCLE      (cycle_bus),
        .REP        (rep_bus),
        .STEP       (STEP),
        .SEGMENT    (SEGMENT),
        .IDX        (IDX),
        .STOP       (STOP),
        .PENDING    (PENDING),
        .REQ_ERR    (REQ_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive one cycle of inputs, let the edge sample them, then sample outputs 1 time unit later.
    task automatic tick(input logic s, input logic u, input logic [1:0] rs, input logic m);
        STEP        = s;
        UPDATE      = u;
        REQ_SEGMENT = rs;
        REQ_MODE    = m;
        @(posedge CLK);
        #1;
        STEP   = 1'b0;
        UPDATE = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        STEP = 1'b0; UPDATE = 1'b0; REQ_SEGMENT = 2'd0; REQ_MODE = 1'b0;
        for (int i = 0; i < NS; i++) begin
            cyc_s[i] = '0;
            rep_s[i] = '1;
        end
        @(posedge CLK); @(posedge CLK); #1;
        checks++;
        if ({SEGMENT, IDX, STOP, PENDING, REQ_ERR} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got seg=%0d idx=%0d stop=%0b pend=%0b err=%0b want all 0",
                     SEGMENT, IDX, STOP, PENDING, REQ_ERR);
        end
        RST = 1'b0;
        #1;
    endtask

    task automatic test_infinite_loop();
        int exp_idx [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
        cyc_s[1] = 15'd3;
        rep_s[1] = 16'hffff;
        tick(1'b0, 1'b1, 2'd1, 1'b0);
        checks++;
        if (SEGMENT !== 2'd1 || IDX !== '0) begin
            errors++;
            $display("FAIL t1_imm_seg1 got seg=%0d idx=%0d want seg=1 idx=0", SEGMENT, IDX);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 2'd0, 1'b0);
            checks++;
            if (IDX !== IW'(exp_idx[i]) || STOP !== 1'b0) begin
                errors++;
                $display("FAIL t1_step%0d got idx=%0d stop=%0b want idx=%0d stop=0",
                         i + 1, IDX, STOP, exp_idx[i]);
            end
        end
    endtask

    task automatic test_finite_repeat();
        int   exp_idx  [7] = '{1, 2, 0, 1, 2, 2, 2};
        logic exp_stop [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        cyc_s[0] = 15'd2;
        rep_s[0] = 16'd1;
        tick(1'b0, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, 2'd0, 1'b0);
            checks++;
            if (IDX !== IW'(exp_idx[i]) || STOP !== exp_stop[i]) begin
                errors++;
                $display("FAIL t2_step%0d got idx=%0d stop=%0b want idx=%0d stop=%0b",
                         i + 1, IDX, STOP, exp_idx[i], exp_stop[i]);
            end
        end
    endtask

    task automatic test_sync_wrap();
        int exp_idx [3] = '{2, 3, 4};
        cyc_s[0] = 15'd4;
        rep_s[0] = 16'hffff;
        cyc_s[1] = 15'd1;
        tick(1'b0, 1'b1, 2'd0, 1'b0);
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        tick(1'b0, 1'b1, 2'd1, 1'b1);
        checks++;
        if (PENDING !== 1'b1 || SEGMENT !== 2'd0 || IDX !== IW'(1)) begin
            errors++;
            $display("FAIL t3_pending got pend=%0b seg=%0d idx=%0d want pend=1 seg=0 idx=1",
                     PENDING, SEGMENT, IDX);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 2'd0, 1'b0);
            checks++;
            if (IDX !== IW'(exp_idx[i]) || SEGMENT !== 2'd0 || PENDING !== 1'b1) begin
                errors++;
                $display("FAIL t3_step%0d got seg=%0d idx=%0d pend=%0b want seg=0 idx=%0d pend=1",
                         i + 1, SEGMENT, IDX, PENDING, exp_idx[i]);
            end
        end
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        checks++;
        if (SEGMENT !== 2'd1 || IDX !== '0 || PENDING !== 1'b0) begin
            errors++;
            $display("FAIL t3_swap got seg=%0d idx=%0d pend=%0b want seg=1 idx=0 pend=0",
                     SEGMENT, IDX, PENDING);
        end
        // seg1 now plays with its latched last index of 1
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        checks++;
        if (SEGMENT !== 2'd1 || IDX !== '0) begin
            errors++;
            $display("FAIL t3_seg1_wrap got seg=%0d idx=%0d want seg=1 idx=0", SEGMENT, IDX);
        end
    endtask

    task automatic test_simultaneous();
        tick(1'b0, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 2'd0, 1'b0);
        // Wrap step and SYNC_WRAP request together: wrap stays in seg0, request stays pending.
        tick(1'b1, 1'b1, 2'd1, 1'b1);
        checks++;
        if (SEGMENT !== 2'd0 || IDX !== '0 || PENDING !== 1'b1) begin
            errors++;
            $display("FAIL t4_same_cycle got seg=%0d idx=%0d pend=%0b want seg=0 idx=0 pend=1",
                     SEGMENT, IDX, PENDING);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 2'd0, 1'b0);
        checks++;
        if (SEGMENT !== 2'd0 || IDX !== IW'(4) || PENDING !== 1'b1) begin
            errors++;
            $display("FAIL t4_before_wrap got seg=%0d idx=%0d pend=%0b want seg=0 idx=4 pend=1",
                     SEGMENT, IDX, PENDING);
        end
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        checks++;
        if (SEGMENT !== 2'd1 || IDX !== '0 || PENDING !== 1'b0) begin
            errors++;
            $display("FAIL t4_next_wrap got seg=%0d idx=%0d pend=%0b want seg=1 idx=0 pend=0",
                     SEGMENT, IDX, PENDING);
        end
        tick(1'b0, 1'b1, 2'd2, 1'b1);
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        tick(1'b0, 1'b1, 2'd0, 1'b0);
        checks++;
        if (SEGMENT !== 2'd0 || IDX !== '0 || PENDING !== 1'b0) begin
            errors++;
            $display("FAIL t4_imm_cancel got seg=%0d idx=%0d pend=%0b want seg=0 idx=0 pend=0",
                     SEGMENT, IDX, PENDING);
        end
        // IMMEDIATE together with STEP: STEP discarded.
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        tick(1'b1, 1'b1, 2'd0, 1'b0);
        checks++;
        if (SEGMENT !== 2'd0 || IDX !== '0) begin
            errors++;
            $display("FAIL t4_imm_step got seg=%0d idx=%0d want seg=0 idx=0", SEGMENT, IDX);
        end
    endtask

    task automatic test_req_err();
        tick(1'b0, 1'b1, 2'd1, 1'b1);
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        tick(1'b0, 1'b1, 2'd3, 1'b0);
        checks++;
        if (REQ_ERR !== 1'b1 || SEGMENT !== 2'd0 || IDX !== IW'(1) || PENDING !== 1'b1) begin
            errors++;
            $display("FAIL t5_err got err=%0b seg=%0d idx=%0d pend=%0b want err=1 seg=0 idx=1 pend=1",
                     REQ_ERR, SEGMENT, IDX, PENDING);
        end
        tick(1'b0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (REQ_ERR !== 1'b0 || IDX !== IW'(1) || PENDING !== 1'b1) begin
            errors++;
            $display("FAIL t5_err_pulse got err=%0b idx=%0d pend=%0b want err=0 idx=1 pend=1",
                     REQ_ERR, IDX, PENDING);
        end
        tick(1'b0, 1'b1, 2'd0, 1'b0);
    endtask

    task automatic test_stopped_swap_and_reset();
        cyc_s[0] = 15'd2;
        rep_s[0] = 16'd0;
        cyc_s[1] = 15'd1;
        tick(1'b0, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 2'd0, 1'b0);
        checks++;
        if (STOP !== 1'b1 || IDX !== IW'(2)) begin
            errors++;
            $display("FAIL t6_stopped got stop=%0b idx=%0d want stop=1 idx=2", STOP, IDX);
        end
        tick(1'b0, 1'b1, 2'd1, 1'b1);
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        checks++;
        if (SEGMENT !== 2'd1 || IDX !== '0 || STOP !== 1'b0 || PENDING !== 1'b0) begin
            errors++;
            $display("FAIL t6_swap got seg=%0d idx=%0d stop=%0b pend=%0b want seg=1 idx=0 stop=0 pend=0",
                     SEGMENT, IDX, STOP, PENDING);
        end
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        tick(1'b0, 1'b1, 2'd0, 1'b1);
        RST = 1'b1;
        #1;
        checks++;
        if ({SEGMENT, IDX, STOP, PENDING, REQ_ERR} !== '0) begin
            errors++;
            $display("FAIL t6_async_rst got seg=%0d idx=%0d stop=%0b pend=%0b err=%0b want all 0",
                     SEGMENT, IDX, STOP, PENDING, REQ_ERR);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        // After reset cyc=0 and rep=all-ones: each STEP wraps to 0, and the earlier request is gone.
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        checks++;
        if (SEGMENT !== 2'd0 || IDX !== '0 || STOP !== 1'b0 || PENDING !== 1'b0) begin
            errors++;
            $display("FAIL t6_after_rst got seg=%0d idx=%0d stop=%0b pend=%0b want 0 0 0 0",
                     SEGMENT, IDX, STOP, PENDING);
        end
        tick(1'b0, 1'b1, 2'd1, 1'b1);
        tick(1'b1, 1'b0, 2'd0, 1'b0);
        checks++;
        if (SEGMENT !== 2'd1 || IDX !== '0 || PENDING !== 1'b0) begin
            errors++;
            $display("FAIL t6_cyc0_swap got seg=%0d idx=%0d pend=%0b want seg=1 idx=0 pend=0",
                     SEGMENT, IDX, PENDING);
        end
    endtask

    initial begin
        test_reset();
        test_infinite_loop();
        test_finite_repeat();
        test_sync_wrap();
        test_simultaneous();
        test_req_err();
        test_stopped_swap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
